branch_compare_unit: RTL and testbench

Multi-cycle operand comparator that produces the equ/lt/ltu condition flags consumed by the branch decision logic.
- Compares rs1 against rs2 CHUNK bits per cycle, LSB-first, through a start/done handshake.
- Sits between the register-read stage and the branch decision logic, replacing the single-cycle full-width comparator.
- Flags are registered and held stable after done_o until the next accepted comparison.

---
 rtl/branch_compare_unit_pkg.sv | 19 +
 rtl/branch_cmp_chunk.sv | 14 +
 rtl/branch_compare_unit.sv | 128 ++++++++++++
 tb/tb_branch_compare_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_compare_unit_pkg.sv
// Shared types and sizing helpers for the chunked branch operand comparator.
package branch_compare_unit_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } bcu_state_e;

    localparam int unsigned DefaultXlen   = 32;
    localparam int unsigned DefaultChunk  = 8;
    localparam int unsigned DefaultNchunk = DefaultXlen / DefaultChunk;

    // Chunk counter width, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/branch_cmp_chunk.sv
// Combinational equality and unsigned less-than for one operand chunk.
module branch_cmp_chunk #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    output logic             eq_o,
    output logic             ltu_o
);

    assign eq_o  = (a_i == b_i);
    assign ltu_o = (a_i < b_i);

endmodule

// File: rtl/branch_compare_unit.sv
// Multi-cycle rs1/rs2 comparator producing equ/lt/ltu branch flags, CHUNK bits per
// cycle LSB-first, with a start/done handshake and pipeline flush.
module branch_compare_unit
    import branch_compare_unit_pkg::*;
#(
    parameter int unsigned XLEN  = DefaultXlen,
    parameter int unsigned CHUNK = DefaultChunk
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            ready_o,
    output logic            done_o,
    output logic            equ_o,
    output logic            lt_o,
    output logic            ltu_o
);

    localparam int unsigned NCHUNK = XLEN / CHUNK;
    localparam int unsigned CntW   = cnt_width(NCHUNK);
    localparam logic [CntW-1:0] CntLast = CntW'(NCHUNK - 1);

    if (XLEN % CHUNK != 0) begin : gen_chunk_check
        $error("branch_compare_unit: XLEN must be a multiple of CHUNK");
    end

    bcu_state_e      state_q, state_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            equ_acc_q, equ_acc_d, ltu_acc_q, ltu_acc_d;
    logic            equ_q, equ_d, lt_q, lt_d, ltu_q, ltu_d;

    logic chunk_eq, chunk_ltu, equ_step, ltu_step;

    branch_cmp_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a_i   (a_q[CHUNK-1:0]),
        .b_i   (b_q[CHUNK-1:0]),
        .eq_o  (chunk_eq),
        .ltu_o (chunk_ltu)
    );

    // Higher chunks are seen later, so a differing chunk overrides the running ltu.
    assign equ_step = equ_acc_q & chunk_eq;
    assign ltu_step = chunk_eq ? ltu_acc_q : chunk_ltu;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        equ_acc_d = equ_acc_q;
        ltu_acc_d = ltu_acc_q;
        equ_d     = equ_q;
        lt_d      = lt_q;
        ltu_d     = ltu_q;
        unique case (state_q)
            StIdle: begin
                if (start_i && !flush_i) begin
                    state_d   = StBusy;
                    a_d       = rs1_i;
                    b_d       = rs2_i;
                    cnt_d     = '0;
                    equ_acc_d = 1'b1;
                    ltu_acc_d = 1'b0;
                end
            end
            StBusy: begin
                equ_acc_d = equ_step;
                ltu_acc_d = ltu_step;
                a_d       = a_q >> CHUNK;
                b_d       = b_q >> CHUNK;
                if (cnt_q == CntLast) begin
                    // Final chunk holds the sign bits; a sign split decides lt directly.
                    equ_d   = equ_step;
                    ltu_d   = ltu_step;
                    lt_d    = (a_q[CHUNK-1] != b_q[CHUNK-1]) ? a_q[CHUNK-1] : ltu_step;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (flush_i) begin
            state_d = StIdle;
            equ_d   = equ_q;
            lt_d    = lt_q;
            ltu_d   = ltu_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            equ_acc_q <= 1'b0;
            ltu_acc_q <= 1'b0;
            equ_q     <= 1'b0;
            lt_q      <= 1'b0;
            ltu_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            equ_acc_q <= equ_acc_d;
            ltu_acc_q <= ltu_acc_d;
            equ_q     <= equ_d;
            lt_q      <= lt_d;
            ltu_q     <= ltu_d;
        end
    end

    assign ready_o = (state_q == StIdle);
    assign done_o  = (state_q == StDone);
    assign equ_o   = equ_q;
    assign lt_o    = lt_q;
    assign ltu_o   = ltu_q;

endmodule

// File: tb/tb_branch_compare_unit.sv
// Directed-vector bench for branch_compare_unit (default and CHUNK=32 configurations).
module tb_branch_compare_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i, start32;
    logic [31:0] rs1_i, rs2_i;
    logic        flush_i;
    logic        ready_o, done_o, equ_o, lt_o, ltu_o;
    logic        ready32, done32, equ32, lt32, ltu32;

    int n_total = 0;
    int n_bad   = 0;
    logic [2:0] prev_flags;

    always #5 clk_i = ~clk_i;

    branch_compare_unit #(
        .XLEN  (32),
        .CHUNK (8)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (start_i),
        .rs1_i   (rs1_i),
        .rs2_i   (rs2_i),
        .flush_i (flush_i),
        .ready_o (ready_o),
        .done_o  (done_o),
        .equ_o   (equ_o),
        .lt_o    (lt_o),
        .ltu_o   (ltu_o)
    );

    branch_compare_unit #(
        .XLEN  (32),
        .CHUNK (32)
    ) dut32 (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (start32),
        .rs1_i   (rs1_i),
        .rs2_i   (rs2_i),
        .flush_i (flush_i),
        .ready_o (ready32),
        .done_o  (done32),
        .equ_o   (equ32),
        .lt_o    (lt32),
        .ltu_o   (ltu32)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    // Issue one comparison from idle; check latency, held flags while busy, and the result.
    task automatic run_cmp(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] exp_flags);
        int  lat;
        bit  seen;
        check_eq({tag, "_ready"}, 32'(ready_o), 32'd1);
        rs1_i   = a;
        rs2_i   = b;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        lat  = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            lat++;
            if (done_o) seen = 1;
            else check_eq({tag, "_hold"}, 32'({equ_o, lt_o, ltu_o}), 32'(prev_flags));
        end
        check_eq({tag, "_lat"}, 32'(lat), 32'd4);
        check_eq({tag, "_flags"}, 32'({equ_o, lt_o, ltu_o}), 32'(exp_flags));
        prev_flags = exp_flags;
        step();
        check_eq({tag, "_pulse"}, 32'(done_o), 32'd0);
        check_eq({tag, "_idle"}, 32'(ready_o), 32'd1);
    endtask

    logic [31:0] b2b_a [3];
    logic [31:0] b2b_b [3];
    logic [2:0]  b2b_f [3];

    initial begin
        int lat;
        int since;
        bit seen;
        rst_ni  = 1'b0;
        start_i = 1'b0;
        start32 = 1'b0;
        flush_i = 1'b0;
        rs1_i   = '0;
        rs2_i   = '0;
        prev_flags = 3'b000;
        step();
        step();
        rst_ni = 1'b1;
        check_eq("rst_state", 32'({ready_o, done_o, equ_o, lt_o, ltu_o}), 32'b10000);
        step();

        // flags are {equ, lt, ltu}
        run_cmp("equal", 32'hDEADBEEF, 32'hDEADBEEF, 3'b100);

        // Flush mid-flight: no done, flags keep the equal result.
        rs1_i   = 32'h1;
        rs2_i   = 32'h2;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check_eq("flush_ready", 32'(ready_o), 32'd1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done_o) seen = 1;
            step();
        end
        check_eq("flush_nodone", 32'(seen), 32'd0);
        check_eq("flush_flags", 32'({equ_o, lt_o, ltu_o}), 32'b100);

        // Start together with flush in idle is not accepted.
        start_i = 1'b1;
        flush_i = 1'b1;
        step();
        start_i = 1'b0;
        flush_i = 1'b0;
        check_eq("flush_start_rej", 32'(ready_o), 32'd1);

        run_cmp("sign_neg", 32'hFFFFFFFF, 32'h00000001, 3'b010);
        run_cmp("sign_swp", 32'h00000001, 32'hFFFFFFFF, 3'b001);
        run_cmp("sign_pos", 32'h00000005, 32'h80000000, 3'b001);
        run_cmp("low_diff", 32'h12345600, 32'h12345601, 3'b011);
        run_cmp("hi_over",  32'h010000FF, 32'h00FFFF00, 3'b000);
        run_cmp("min_max",  32'h80000000, 32'h7FFFFFFF, 3'b010);

        // Back-to-back with start held high.
        b2b_a[0] = 32'h00000003; b2b_b[0] = 32'h00000300; b2b_f[0] = 3'b011;
        b2b_a[1] = 32'hC0000000; b2b_b[1] = 32'hC0000001; b2b_f[1] = 3'b011;
        b2b_a[2] = 32'h00FF00FF; b2b_b[2] = 32'h00FF00FF; b2b_f[2] = 3'b100;
        rs1_i   = b2b_a[0];
        rs2_i   = b2b_b[0];
        start_i = 1'b1;
        since   = 0;
        for (int k = 0; k < 3; k++) begin
            seen = 0;
            lat  = 0;
            for (int i = 0; i < 20 && !seen; i++) begin
                step();
                lat++;
                if (done_o) seen = 1;
            end
            if (k == 0) check_eq("b2b_first", 32'(lat), 32'd5);
            else check_eq("b2b_interval", 32'(lat), 32'd6);
            check_eq("b2b_flags", 32'({equ_o, lt_o, ltu_o}), 32'(b2b_f[k]));
            if (k < 2) begin
                rs1_i = b2b_a[k+1];
                rs2_i = b2b_b[k+1];
            end
        end
        start_i = 1'b0;
        step();
        step();
        check_eq("b2b_idle", 32'(ready_o), 32'd1);

        // Reset mid-busy: outputs return to reset values, no done afterwards.
        rs1_i   = 32'h5;
        rs2_i   = 32'h9;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        check_eq("rst_busy", 32'({ready_o, done_o, equ_o, lt_o, ltu_o}), 32'b10000);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done_o) seen = 1;
            step();
        end
        check_eq("rst_nodone", 32'(seen), 32'd0);

        // CHUNK = XLEN: single busy cycle.
        rs1_i   = 32'hFFFFFFFF;
        rs2_i   = 32'h00000001;
        start32 = 1'b1;
        step();
        start32 = 1'b0;
        seen = 0;
        lat  = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            lat++;
            if (done32) seen = 1;
        end
        check_eq("c32_lat", 32'(lat), 32'd1);
        check_eq("c32_flags", 32'({equ32, lt32, ltu32}), 32'b010);
        step();
        check_eq("c32_ready", 32'(ready32), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
